// File: rtl/saes_key_expand.sv
// S-AES key schedule: latches a 16-bit cipher key on start and streams round
// keys K0, K1, K2 over a valid/ready handshake, one expansion step per transfer.

module saes_sbox_nib (
    input  logic [3:0] nib,
    output logic [3:0] sub
);
    always_comb begin
        sub = 4'h0;
        case (nib)
            4'h0: sub = 4'h9;
            4'h1: sub = 4'h4;
            4'h2: sub = 4'hA;
            4'h3: sub = 4'hB;
            4'h4: sub = 4'hD;
            4'h5: sub = 4'h1;
            4'h6: sub = 4'h8;
            4'h7: sub = 4'h5;
            4'h8: sub = 4'h6;
            4'h9: sub = 4'h2;
            4'hA: sub = 4'h0;
            4'hB: sub = 4'h3;
            4'hC: sub = 4'hC;
            4'hD: sub = 4'hE;
            4'hE: sub = 4'hF;
            4'hF: sub = 4'h7;
            default: sub = 4'h0;
        endcase
    end
endmodule

module saes_key_expand #(
    parameter logic [7:0] RCON1 = 8'h80,
    parameter logic [7:0] RCON2 = 8'h30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] key_in,
    input  logic        key_ready,
    output logic [15:0] key_out,
    output logic [1:0]  key_idx,
    output logic        key_valid,
    output logic        busy,
    output logic        done
);
    localparam int NUM_NIBS = 2;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t      state, state_nxt;
    logic [15:0] key_nxt;
    logic [1:0]  idx_nxt;
    logic        valid_nxt, busy_nxt, done_nxt;

    logic [7:0]  rot_b, sub_b, rcon, a_new, b_new;

    // Next word pair is derived from the key currently presented, so the
    // expansion advances exactly once per accepted transfer.
    assign rot_b = {key_out[3:0], key_out[7:4]};

    genvar g;
    generate
        for (g = 0; g < NUM_NIBS; g++) begin : g_sbox
            saes_sbox_nib u_sbox (
                .nib (rot_b[g*4 +: 4]),
                .sub (sub_b[g*4 +: 4])
            );
        end
    endgenerate

    assign rcon  = (key_idx == 2'd0) ? RCON1 : RCON2;
    assign a_new = key_out[15:8] ^ rcon ^ sub_b;
    assign b_new = a_new ^ key_out[7:0];

    always_comb begin
        state_nxt = state;
        key_nxt   = key_out;
        idx_nxt   = key_idx;
        valid_nxt = key_valid;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    key_nxt   = key_in;
                    idx_nxt   = 2'd0;
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (key_ready) begin
                    // idx 3 is unreachable; treat it as final so the FSM cannot stall
                    if (key_idx >= 2'd2) begin
                        valid_nxt = 1'b0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        key_nxt = {a_new, b_new};
                        idx_nxt = key_idx + 2'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            key_out   <= 16'h0;
            key_idx   <= 2'd0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            key_out   <= key_nxt;
            key_idx   <= idx_nxt;
            key_valid <= valid_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end
endmodule

// File: tb/tb_saes_key_expand.sv
// Bench for saes_key_expand: directed scenarios plus random traffic, all
// checked every cycle against a key-list model of the schedule.

module tb_saes_key_expand;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] key_in = 16'h0;
    logic        key_ready = 1'b0;
    logic [15:0] key_out;
    logic [1:0]  key_idx;
    logic        key_valid, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    saes_key_expand dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .key_ready (key_ready),
        .key_out   (key_out),
        .key_idx   (key_idx),
        .key_valid (key_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] SBOX [16] = '{4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
                                         4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};

    function automatic logic [15:0] next_key(input logic [15:0] k, input logic [7:0] rc);
        logic [7:0] a, b, r, s, an;
        a  = k[15:8];
        b  = k[7:0];
        r  = {b[3:0], b[7:4]};
        s  = {SBOX[r[7:4]], SBOX[r[3:0]]};
        an = a ^ rc ^ s;
        return {an, an ^ b};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the full key list is computed at start; the handshake only walks it.
    logic [15:0] m_keys [3];
    logic [15:0] m_key;
    int          m_idx;
    logic        m_valid, m_busy, m_done;

    always @(negedge clk) begin
        if (rst) begin
            m_key = 16'h0; m_idx = 0; m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        end else begin
            chk("key_valid", {31'd0, key_valid}, {31'd0, m_valid});
            chk("busy",      {31'd0, busy},      {31'd0, m_busy});
            chk("done",      {31'd0, done},      {31'd0, m_done});
            chk("key_out",   {16'd0, key_out},   {16'd0, m_key});
            chk("key_idx",   {30'd0, key_idx},   m_idx);
            m_done = 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_keys[0] = key_in;
                    m_keys[1] = next_key(key_in, 8'h80);
                    m_keys[2] = next_key(m_keys[1], 8'h30);
                    m_key = m_keys[0]; m_idx = 0; m_valid = 1'b1; m_busy = 1'b1;
                end
            end else if (key_ready) begin
                if (m_idx == 2) begin
                    m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b1;
                end else begin
                    m_idx++;
                    m_key = m_keys[m_idx];
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Pin the model against hand-derived vectors.
        chk("model A73B K1", {16'd0, next_key(16'hA73B, 8'h80)}, 32'h1C27);
        chk("model A73B K2", {16'd0, next_key(16'h1C27, 8'h30)}, 32'h7651);
        chk("model 4AF5 K1", {16'd0, next_key(16'h4AF5, 8'h80)}, 32'hDD28);
        chk("model 4AF5 K2", {16'd0, next_key(16'hDD28, 8'h30)}, 32'h87AF);
        chk("model 0000 K1", {16'd0, next_key(16'h0000, 8'h80)}, 32'h1919);

        // 1: reset
        #3;
        chk("rst key_out", {16'd0, key_out}, 32'h0);
        chk("rst flags", {28'd0, key_valid, busy, done, 1'b0}, 32'h0);
        tick; rst = 1'b0;
        repeat (5) tick;
        chk("idle flags", {29'd0, key_valid, busy, done}, 32'h0);

        // 2: textbook vector, ready held high
        key_ready = 1'b1; start = 1'b1; key_in = 16'hA73B;
        tick; start = 1'b0;
        chk("t2 K0", {14'd0, key_idx, key_out}, {14'd0, 2'd0, 16'hA73B});
        tick; chk("t2 K1", {14'd0, key_idx, key_out}, {14'd0, 2'd1, 16'h1C27});
        tick; chk("t2 K2", {14'd0, key_idx, key_out}, {14'd0, 2'd2, 16'h7651});
        tick; chk("t2 done", {30'd0, done, busy}, 32'h2);
        tick;

        // 3: backpressure
        key_ready = 1'b0; start = 1'b1; key_in = 16'h4AF5;
        tick; start = 1'b0;
        repeat (3) begin chk("t3 hold K0", {16'd0, key_out}, 32'h4AF5); tick; end
        key_ready = 1'b1; tick; key_ready = 1'b0;
        repeat (3) begin chk("t3 hold K1", {16'd0, key_out}, 32'hDD28); tick; end
        key_ready = 1'b1; tick; key_ready = 1'b0;
        repeat (3) begin
            chk("t3 hold K2", {16'd0, key_out}, 32'h87AF);
            chk("t3 no done", {31'd0, done}, 32'h0);
            tick;
        end
        key_ready = 1'b1; tick;
        chk("t3 done", {31'd0, done}, 32'h1);
        tick;

        // 4: start while busy is ignored
        start = 1'b1; key_in = 16'hA73B;
        tick; start = 1'b1; key_in = 16'hFFFF;
        tick; start = 1'b0;
        chk("t4 K1", {16'd0, key_out}, 32'h1C27);
        tick; chk("t4 K2", {16'd0, key_out}, 32'h7651);
        tick; chk("t4 done", {31'd0, done}, 32'h1);
        tick;

        // 5: restart in the done cycle
        start = 1'b1; key_in = 16'h4AF5;
        tick; start = 1'b0;
        tick; tick; tick;
        chk("t5 done", {31'd0, done}, 32'h1);
        start = 1'b1; key_in = 16'hA73B;
        tick; start = 1'b0;
        chk("t5 K0", {13'd0, done, key_idx, key_out}, {13'd0, 1'b0, 2'd0, 16'hA73B});
        repeat (3) tick;

        // 6: reset while K1 is valid, then an all-zero key
        key_ready = 1'b0; start = 1'b1; key_in = 16'hA73B;
        tick; start = 1'b0; key_ready = 1'b1;
        tick; key_ready = 1'b0;
        chk("t6 K1 before rst", {16'd0, key_out}, 32'h1C27);
        #2 rst = 1'b1;
        #1 chk("t6 rst async", {30'd0, key_valid, busy}, 32'h0);
        tick; rst = 1'b0; key_ready = 1'b1;
        repeat (4) tick;
        start = 1'b1; key_in = 16'h0000;
        tick; start = 1'b0;
        chk("t6 K0", {16'd0, key_out}, 32'h0000);
        tick; chk("t6 K1", {16'd0, key_out}, 32'h1919);
        tick; chk("t6 K2", {16'd0, key_out}, {16'd0, next_key(16'h1919, 8'h30)});
        tick;

        // Random traffic, checked by the model on every cycle.
        for (int i = 0; i < 400; i++) begin
            start     = ($urandom_range(0, 3) == 0);
            key_ready = ($urandom_range(0, 2) != 0);
            key_in    = 16'($urandom);
            tick;
        end
        start = 1'b0; key_ready = 1'b1;
        repeat (6) tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
